ad_chan_sched: RTL

//  Sequences multi-channel sampling of the dual-bus ADC front end (ACM9226 style, one 12-bit bus per channel).
//  A rate divider starts a sampling round. Each round visits every enabled channel in ascending index order.

---
 rtl/ad_pkg.sv | 19 +
 rtl/ad_rr_pick.sv | 26 ++
 rtl/ad_chan_sched.sv | 136 +++++++++++++
 3 files changed

// File: rtl/ad_pkg.sv
// Shared types and helpers for the ADC channel scheduler.
package ad_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, SETTLE, CAPTURE} state_e;

  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Reverse the low w bits of x; the converter drives its MSB on pin 0.
  function automatic logic [31:0] bit_rev(input logic [31:0] x, input int w);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 32; k++)
      if (k < w) r[k] = x[w-1-k];
    return r;
  endfunction

endpackage

// File: rtl/ad_rr_pick.sv
// Finds the lowest set mask bit strictly above cur_i; cur_i = -1 yields the lowest set bit.
module ad_rr_pick #(
  parameter int NUM_CH = 2,
  parameter int CH_W   = 1
) (
  input  logic [NUM_CH-1:0] mask_i,
  input  logic signed [CH_W:0] cur_i,
  output logic [CH_W-1:0]   idx_o,
  output logic              found_o
);

  logic hit;

  always_comb begin
    hit   = 1'b0;
    idx_o = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!hit && mask_i[i] && (i > int'(cur_i))) begin
        hit   = 1'b1;
        idx_o = CH_W'(i);
      end
    end
    found_o = hit;
  end

endmodule

// File: rtl/ad_chan_sched.sv
// Round-based multi-channel ADC sampler: rate divider, per-channel settle wait,
// bit-reversed capture into a valid/ready output register, sticky overrun.
module ad_chan_sched
  import ad_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int DATA_W  = 12,
  parameter int DIV_W   = 16,
  parameter int LATENCY = 7,
  localparam int CH_W   = ch_w(NUM_CH)
) (
  input  logic                     ad_clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [NUM_CH-1:0]        ch_mask,
  input  logic [DIV_W-1:0]         rate_div,
  input  logic [NUM_CH*DATA_W-1:0] ad_in,
  output logic [DATA_W-1:0]        sample_data,
  output logic [CH_W-1:0]          sample_ch,
  output logic                     sample_valid,
  input  logic                     sample_ready,
  output logic                     frame_done,
  output logic                     overrun,
  input  logic                     overrun_clr,
  output logic                     busy
);

  localparam int SW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e              state_q;
  logic [DIV_W-1:0]    rate_q;
  logic [SW-1:0]       set_q;
  logic [NUM_CH-1:0]   mask_q;
  logic [CH_W-1:0]     ch_q;
  logic                vld_q, ovr_q, last_q, fd_q;
  logic [DATA_W-1:0]   data_q;
  logic [CH_W-1:0]     sch_q;

  logic [CH_W-1:0]     lo_idx, nx_idx;
  logic                lo_found, nx_found;
  logic                tick, cap, can_load, ovr_set;
  logic [DATA_W-1:0]   cap_data_d;
  logic [DIV_W-1:0]    rate_d;

  ad_rr_pick #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_pick_lo (
    .mask_i  (ch_mask),
    .cur_i   ({(CH_W+1){1'b1}}),
    .idx_o   (lo_idx),
    .found_o (lo_found)
  );

  ad_rr_pick #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_pick_nx (
    .mask_i  (mask_q),
    .cur_i   ({1'b0, ch_q}),
    .idx_o   (nx_idx),
    .found_o (nx_found)
  );

  always_comb begin
    tick       = enable && (state_q != IDLE) && (rate_q == rate_div);
    cap        = enable && (state_q == CAPTURE);
    can_load   = !vld_q || sample_ready;
    // A tick while a round is still in flight is lost, not queued.
    ovr_set    = (tick && (state_q != WAIT)) || (cap && !can_load);
    cap_data_d = DATA_W'(bit_rev(32'(ad_in[ch_q*DATA_W +: DATA_W]), DATA_W));
    if (!enable || state_q == IDLE || tick) rate_d = '0;
    else                                    rate_d = rate_q + DIV_W'(1);
  end

  always_ff @(posedge ad_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rate_q  <= '0;
      set_q   <= '0;
      mask_q  <= '0;
      ch_q    <= '0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      sch_q   <= '0;
      ovr_q   <= 1'b0;
      last_q  <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      rate_q <= rate_d;
      last_q <= 1'b0;
      fd_q   <= last_q;

      if (ovr_set)          ovr_q <= 1'b1;
      else if (overrun_clr) ovr_q <= 1'b0;

      if (cap && can_load) begin
        vld_q  <= 1'b1;
        data_q <= cap_data_d;
        sch_q  <= ch_q;
      end else if (vld_q && sample_ready) begin
        vld_q  <= 1'b0;
      end

      if (!enable) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE:    if (|ch_mask) state_q <= WAIT;
          WAIT:
            if (tick && lo_found) begin
              mask_q  <= ch_mask;
              ch_q    <= lo_idx;
              set_q   <= '0;
              state_q <= SETTLE;
            end
          SETTLE:
            if (set_q == SW'(LATENCY-1)) state_q <= CAPTURE;
            else                         set_q   <= set_q + SW'(1);
          CAPTURE:
            if (nx_found) begin
              ch_q    <= nx_idx;
              set_q   <= '0;
              state_q <= SETTLE;
            end else begin
              last_q  <= 1'b1;
              state_q <= WAIT;
            end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign sample_data  = data_q;
  assign sample_ch    = sch_q;
  assign sample_valid = vld_q;
  assign frame_done   = fd_q;
  assign overrun      = ovr_q;
  assign busy         = (state_q != IDLE);

endmodule
